invalidate_packet_multi: RTL and testbench
==========================================

// Module: invalidate_packet_multi
// PURPOSE
//  RX MAC error aggregator for up to NUM_SRC error sources. Typical sources: CRC, GMII rx_er, parser error bits.
//  Masks the sources, then issues one invalidate pulse per bad frame and holds ERROR until the frame ends.
//  Latches a per-source cause vector and keeps a saturating bad-frame count.
//  Sits between the GMII RX / CRC / parser stages and the RX packet FIFO drop logic.
// PARAMETERS
//  NUM_SRC  4   number of error source inputs (1..32)
//  CNT_W    16  width of bad-frame and per-source counters (>=2)
// PORTS
//  clk            in   1             single clock
//  rst_n          in   1             asynchronous active-low reset
//  frame_valid_i  in   1             GMII rx valid (frame in progress)
//  src_err_i      in   NUM_SRC       raw error strobes, one per source
//  src_mask_i     in   NUM_SRC       1 = source enabled; quasi-static
//  clr_cnt_i      in   1             synchronous clear of all counters
//  error_pulse_o  out  1             1-cycle invalidate strobe, combinational from inputs
//  frame_bad_o    out  1             high while state == ERROR (registered)
//  cause_o        out  NUM_SRC       causes accumulated for last/current bad frame
//  cause_valid_o  out  1             1-cycle strobe, cause_o final for that frame
//  bad_cnt_o      out  CNT_W         saturating count of error pulses
//  src_cnt_o      out  NUM_SRC*CNT_W per-source bad-frame counters (see CONFIGURATION)
// BEHAVIOUR
//  - err_vec = src_err_i & src_mask_i.
//  - err_any = |err_vec.
//  - Reset values:
//      state = NO_ERROR; frame_bad_o = 0; cause_o = 0; cause_valid_o = 0.
//      bad_cnt_o = 0; src_cnt_o = 0.
//      error_pulse_o = 0 (follows from state NO_ERROR with no error inputs).
//  - FSM states: NO_ERROR, ERROR.
//  - NO_ERROR:
//      err_any -> error_pulse_o = 1 in the same cycle (0 latency).
//      Next cycle: state = ERROR; cause_o <= err_vec (replaces old value).
//      Applies whether frame_valid_i is 1 or 0, so a late CRC strobe after valid drops still invalidates.
//  - ERROR:
//      error_pulse_o = 0 always; further errors never re-pulse.
//      cause_o <= cause_o | err_vec each cycle.
//      Exit to NO_ERROR when !frame_valid_i && !err_any.
//      cause_valid_o = 1 in the cycle after the exit; cause_o is final and held until the next bad frame.
//  - Back-to-back: a new error in the first NO_ERROR cycle after exit pulses normally. Its cause_o replace
//    is in the same cycle as the previous frame's cause_valid_o, so cause_valid_o sees the old value.
//  - bad_cnt_o:
//      +1 per error_pulse_o, saturates at all-ones (no wrap).
//      clr_cnt_i has priority; clear together with a pulse gives 1.
//  - Mask change mid-frame affects only subsequent cycles; causes already latched are kept.
//  - rst_n asserted mid-frame: immediate return to reset values, no pulse. After release the block starts in NO_ERROR.
//    A frame still in progress with no new error is therefore not invalidated.
// CONFIGURATION
//  INVALIDATE_PER_SRC_CNT_EN defined:
//    src_cnt_o[i] +1 once per bad frame in which source i was set in cause_o.
//    Update happens on the cause_valid_o cycle.
//    Counters saturate at all-ones and are cleared by clr_cnt_i (clear wins).
//  Undefined: src_cnt_o tied to 0; no counter flops.
// TESTING
//  1 valid high 10 cycles, src_err_i=4'b0001 at cycle 3, mask=4'hF:
//    -> error_pulse_o only at cycle 3.
//    -> frame_bad_o from 4 until valid drops.
//    -> cause_valid_o one cycle after exit, cause_o=4'b0001, bad_cnt_o=1.
//  2 frame with src 0 at cycle 2 and src 2 at cycle 5:
//    -> single pulse, final cause_o=4'b0101, bad_cnt_o +1.
//    -> with INVALIDATE_PER_SRC_CNT_EN: src_cnt_o[0]=1, src_cnt_o[2]=1.
//  3 mask=4'b1110, src_err_i=4'b0001 during frame:
//    -> no pulse, frame_bad_o=0, counters unchanged.
//  4 CRC strobe (src 0) one cycle after valid falls:
//    -> pulse that cycle, ERROR one cycle, cause_valid_o with cause_o=4'b0001.
//  5 CNT_W=2, 5 bad frames -> bad_cnt_o=3 (saturated).
//    clr_cnt_i coincident with the next pulse -> bad_cnt_o=1.
//  6 rst_n low while in ERROR mid-frame:
//    -> all outputs 0 asynchronously.
//    -> after release with valid still high and no error: no pulse, frame_bad_o=0.

Source files
------------

// File: rtl/invalidate_packet_multi.sv
// ---------------------------------------------------------------------------
// invalidate_packet_multi
//
// RX MAC error aggregator. Several raw error strobes (CRC, GMII rx_er, parser
// errors, ...) are masked and merged into one invalidate strobe per bad frame.
// The block stays in ERROR until the frame has ended and no error is present.
// It also keeps the per-frame cause vector and a saturating count of
// invalidated frames.
//
// Parameters:
//   NUM_SRC  number of error sources (1..32)
//   CNT_W    width of the bad-frame and per-source counters (>= 2)
//
// Optional feature macro:
//   INVALIDATE_PER_SRC_CNT_EN - when defined, one saturating counter per
//   source is kept. It counts the bad frames whose final cause vector had that
//   source set. When not defined, src_cnt_o is constant zero and has no flops.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   frame_valid_i  frame in progress (GMII rx valid)
//   src_err_i      raw error strobes, one per source
//   src_mask_i     per-source enable (1 = enabled), quasi-static
//   clr_cnt_i      synchronous clear of all counters
//   error_pulse_o  one-cycle invalidate strobe, combinational from the inputs
//   frame_bad_o    high while in the ERROR state
//   cause_o        causes accumulated for the last or current bad frame
//   cause_valid_o  one-cycle strobe: cause_o is final for that frame
//   bad_cnt_o      saturating count of invalidate strobes
//   src_cnt_o      per-source bad-frame counters, source i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module invalidate_packet_multi #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_valid_i,
    input  logic [NUM_SRC-1:0]       src_err_i,
    input  logic [NUM_SRC-1:0]       src_mask_i,
    input  logic                     clr_cnt_i,
    output logic                     error_pulse_o,
    output logic                     frame_bad_o,
    output logic [NUM_SRC-1:0]       cause_o,
    output logic                     cause_valid_o,
    output logic [CNT_W-1:0]         bad_cnt_o,
    output logic [NUM_SRC*CNT_W-1:0] src_cnt_o
);

    typedef enum logic [0:0] {
        ST_NO_ERROR = 1'b0,
        ST_ERROR    = 1'b1
    } state_t;

    // Saturating increment: all-ones is held rather than wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;
    logic               cause_valid_q, cause_valid_d;
    logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [NUM_SRC-1:0] err_vec_s;
    logic               err_any_s;
    logic               pulse_s;

    assign err_vec_s = src_err_i & src_mask_i;
    assign err_any_s = |err_vec_s;

    // Next state, cause accumulation and invalidate strobe.
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        cause_valid_d = 1'b0;
        pulse_s       = 1'b0;
        case (state_q)
            ST_NO_ERROR: begin
                // Not gated by frame_valid_i, so a late CRC strobe still invalidates.
                if (err_any_s) begin
                    pulse_s = 1'b1;
                    state_d = ST_ERROR;
                    cause_d = err_vec_s;
                end else begin
                    state_d = ST_NO_ERROR;
                end
            end
            ST_ERROR: begin
                cause_d = cause_q | err_vec_s;
                if (!frame_valid_i && !err_any_s) begin
                    state_d       = ST_NO_ERROR;
                    cause_valid_d = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_NO_ERROR;
            end
        endcase
    end

    // Bad-frame counter next value: a clear wins, but still counts a coincident pulse.
    always_comb begin
        bad_cnt_d = bad_cnt_q;
        if (clr_cnt_i) begin
            bad_cnt_d = {{(CNT_W-1){1'b0}}, pulse_s};
        end else if (pulse_s) begin
            bad_cnt_d = sat_inc(bad_cnt_q);
        end else begin
            bad_cnt_d = bad_cnt_q;
        end
    end

    // State, cause and bad-frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NO_ERROR;
            cause_q       <= {NUM_SRC{1'b0}};
            cause_valid_q <= 1'b0;
            bad_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
            bad_cnt_q     <= bad_cnt_d;
        end
    end

`ifdef INVALIDATE_PER_SRC_CNT_EN
    logic [NUM_SRC-1:0][CNT_W-1:0] src_cnt_q, src_cnt_d;

    // Per-source counters advance on the cycle where cause_q is final; clear wins.
    always_comb begin
        src_cnt_d = src_cnt_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (clr_cnt_i) begin
                src_cnt_d[i] = {CNT_W{1'b0}};
            end else if (cause_valid_q && cause_q[i]) begin
                src_cnt_d[i] = sat_inc(src_cnt_q[i]);
            end else begin
                src_cnt_d[i] = src_cnt_q[i];
            end
        end
    end

    // Per-source counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cnt_q <= {(NUM_SRC*CNT_W){1'b0}};
        end else begin
            src_cnt_q <= src_cnt_d;
        end
    end

    assign src_cnt_o = src_cnt_q;
`else
    assign src_cnt_o = {(NUM_SRC*CNT_W){1'b0}};
`endif

    assign error_pulse_o = pulse_s;
    assign frame_bad_o   = (state_q == ST_ERROR);
    assign cause_o       = cause_q;
    assign cause_valid_o = cause_valid_q;
    assign bad_cnt_o     = bad_cnt_q;

endmodule

// File: tb/tb_invalidate_packet_multi.sv
// Self-checking bench for invalidate_packet_multi (NUM_SRC=4, CNT_W=2).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
module tb_invalidate_packet_multi;
    localparam int NUM_SRC = 4;
    localparam int CNT_W   = 2;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     frame_valid_i;
    logic [NUM_SRC-1:0]       src_err_i;
    logic [NUM_SRC-1:0]       src_mask_i;
    logic                     clr_cnt_i;
    logic                     error_pulse_o;
    logic                     frame_bad_o;
    logic [NUM_SRC-1:0]       cause_o;
    logic                     cause_valid_o;
    logic [CNT_W-1:0]         bad_cnt_o;
    logic [NUM_SRC*CNT_W-1:0] src_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference model.
    bit                 m_bad;
    logic [NUM_SRC-1:0] m_cause;
    bit                 m_cv;
    int                 m_cnt;
    int                 m_src_cnt [NUM_SRC];

    invalidate_packet_multi #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid_i(frame_valid_i), .src_err_i(src_err_i),
        .src_mask_i(src_mask_i), .clr_cnt_i(clr_cnt_i), .error_pulse_o(error_pulse_o),
        .frame_bad_o(frame_bad_o), .cause_o(cause_o), .cause_valid_o(cause_valid_o),
        .bad_cnt_o(bad_cnt_o), .src_cnt_o(src_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bad = 1'b0; m_cause = '0; m_cv = 1'b0; m_cnt = 0;
        for (int i = 0; i < NUM_SRC; i++) m_src_cnt[i] = 0;
    endtask

    // One clock edge of the frame-level rules, applied to the inputs held at that edge.
    task automatic model_update();
        logic [NUM_SRC-1:0] ev;
        bit any, pulse, ended;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ev    = src_err_i & src_mask_i;
        any   = (ev != 0);
        pulse = !m_bad && any;
        ended = m_bad && !frame_valid_i && !any;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (clr_cnt_i) m_src_cnt[i] = 0;
            else if (m_cv && m_cause[i] && m_src_cnt[i] < MAXC) m_src_cnt[i]++;
        end
        if (clr_cnt_i) m_cnt = pulse ? 1 : 0;
        else if (pulse && m_cnt < MAXC) m_cnt++;
        if (pulse) m_cause = ev;
        else if (m_bad) m_cause = m_cause | ev;
        if (pulse) m_bad = 1'b1;
        else if (ended) m_bad = 1'b0;
        m_cv = ended;
    endtask

    function automatic logic [NUM_SRC*CNT_W-1:0] exp_src_cnt();
        logic [NUM_SRC*CNT_W-1:0] v;
        v = '0;
`ifdef INVALIDATE_PER_SRC_CNT_EN
        for (int i = 0; i < NUM_SRC; i++) v[i*CNT_W +: CNT_W] = m_src_cnt[i][CNT_W-1:0];
`endif
        return v;
    endfunction

    // Per-source counter image for directed tests: returns zero if the feature is off.
    function automatic logic [NUM_SRC*CNT_W-1:0] feat(input logic [NUM_SRC*CNT_W-1:0] v);
`ifdef INVALIDATE_PER_SRC_CNT_EN
        return v;
`else
        return '0;
`endif
    endfunction

    // Advance one cycle: the model takes the edge, then new inputs are applied and the bench waits for mid-cycle.
    task automatic step(input logic v, input logic [NUM_SRC-1:0] e, input logic [NUM_SRC-1:0] m, input logic c);
        @(posedge clk);
        model_update();
        #1;
        frame_valid_i = v; src_err_i = e; src_mask_i = m; clr_cnt_i = c;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_valid_i = 1'b0; src_err_i = '0; src_mask_i = 4'hF; clr_cnt_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (error_pulse_o !== 1'b0) $display("FAIL rst_pulse got %b exp 0", error_pulse_o); else n_pass++;
        n_checks++; if (frame_bad_o !== 1'b0) $display("FAIL rst_frame_bad got %b exp 0", frame_bad_o); else n_pass++;
        n_checks++; if (cause_o !== 4'h0) $display("FAIL rst_cause got %h exp 0", cause_o); else n_pass++;
        n_checks++; if (cause_valid_o !== 1'b0) $display("FAIL rst_cause_valid got %b exp 0", cause_valid_o); else n_pass++;
        n_checks++; if (bad_cnt_o !== 2'd0) $display("FAIL rst_bad_cnt got %0d exp 0", bad_cnt_o); else n_pass++;
        n_checks++; if (src_cnt_o !== 8'h00) $display("FAIL rst_src_cnt got %h exp 0", src_cnt_o); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_error();
        for (int c = 0; c <= 12; c++) begin
            step(c < 10, (c == 3) ? 4'b0001 : 4'b0000, 4'hF, 1'b0);
            n_checks++; if (error_pulse_o !== (c == 3)) $display("FAIL t1_pulse c=%0d got %b exp %b", c, error_pulse_o, c == 3); else n_pass++;
            n_checks++; if (frame_bad_o !== (c >= 4 && c <= 10)) $display("FAIL t1_frame_bad c=%0d got %b", c, frame_bad_o); else n_pass++;
            n_checks++; if (cause_valid_o !== (c == 11)) $display("FAIL t1_cause_valid c=%0d got %b", c, cause_valid_o); else n_pass++;
            if (c == 11) begin
                n_checks++; if (cause_o !== 4'b0001) $display("FAIL t1_cause got %b exp 0001", cause_o); else n_pass++;
                n_checks++; if (bad_cnt_o !== 2'd1) $display("FAIL t1_bad_cnt got %0d exp 1", bad_cnt_o); else n_pass++;
            end
        end
        n_checks++; if (src_cnt_o !== feat(8'h01)) $display("FAIL t1_src_cnt got %h exp %h", src_cnt_o, feat(8'h01)); else n_pass++;
    endtask

    task automatic test_multi_cause();
        for (int c = 0; c <= 12; c++) begin
            step(c < 10, (c == 2) ? 4'b0001 : ((c == 5) ? 4'b0100 : 4'b0000), 4'hF, 1'b0);
            n_checks++; if (error_pulse_o !== (c == 2)) $display("FAIL t2_pulse c=%0d got %b", c, error_pulse_o); else n_pass++;
            n_checks++; if (cause_valid_o !== (c == 11)) $display("FAIL t2_cause_valid c=%0d got %b", c, cause_valid_o); else n_pass++;
        end
        n_checks++; if (cause_o !== 4'b0101) $display("FAIL t2_cause got %b exp 0101", cause_o); else n_pass++;
        n_checks++; if (bad_cnt_o !== 2'd2) $display("FAIL t2_bad_cnt got %0d exp 2", bad_cnt_o); else n_pass++;
        n_checks++; if (src_cnt_o !== feat(8'h12)) $display("FAIL t2_src_cnt got %h exp %h", src_cnt_o, feat(8'h12)); else n_pass++;
    endtask

    task automatic test_masked();
        for (int c = 0; c <= 10; c++) begin
            step(c < 8, (c >= 2 && c <= 6) ? 4'b0001 : 4'b0000, 4'b1110, 1'b0);
            n_checks++; if (error_pulse_o !== 1'b0) $display("FAIL t3_pulse c=%0d got %b exp 0", c, error_pulse_o); else n_pass++;
            n_checks++; if (frame_bad_o !== 1'b0) $display("FAIL t3_frame_bad c=%0d got %b exp 0", c, frame_bad_o); else n_pass++;
            n_checks++; if (cause_valid_o !== 1'b0) $display("FAIL t3_cause_valid c=%0d got %b exp 0", c, cause_valid_o); else n_pass++;
        end
        n_checks++; if (bad_cnt_o !== 2'd2) $display("FAIL t3_bad_cnt got %0d exp 2", bad_cnt_o); else n_pass++;
        n_checks++; if (cause_o !== 4'b0101) $display("FAIL t3_cause got %b exp 0101", cause_o); else n_pass++;
        n_checks++; if (src_cnt_o !== feat(8'h12)) $display("FAIL t3_src_cnt got %h exp %h", src_cnt_o, feat(8'h12)); else n_pass++;
    endtask

    task automatic test_late_crc();
        for (int c = 0; c <= 8; c++) begin
            step(c < 5, (c == 5) ? 4'b0001 : 4'b0000, 4'hF, 1'b0);
            n_checks++; if (error_pulse_o !== (c == 5)) $display("FAIL t4_pulse c=%0d got %b", c, error_pulse_o); else n_pass++;
            n_checks++; if (frame_bad_o !== (c == 6)) $display("FAIL t4_frame_bad c=%0d got %b", c, frame_bad_o); else n_pass++;
            n_checks++; if (cause_valid_o !== (c == 7)) $display("FAIL t4_cause_valid c=%0d got %b", c, cause_valid_o); else n_pass++;
        end
        n_checks++; if (cause_o !== 4'b0001) $display("FAIL t4_cause got %b exp 0001", cause_o); else n_pass++;
        n_checks++; if (bad_cnt_o !== 2'd3) $display("FAIL t4_bad_cnt got %0d exp 3", bad_cnt_o); else n_pass++;
        n_checks++; if (src_cnt_o !== feat(8'h13)) $display("FAIL t4_src_cnt got %h exp %h", src_cnt_o, feat(8'h13)); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 2; f++) begin
            step(1'b1, 4'b0001, 4'hF, 1'b0);
            step(1'b0, 4'b0000, 4'hF, 1'b0);
            step(1'b0, 4'b0000, 4'hF, 1'b0);
        end
        n_checks++; if (bad_cnt_o !== 2'd3) $display("FAIL t5_bad_cnt_sat got %0d exp 3", bad_cnt_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (src_cnt_o !== feat(8'h13)) $display("FAIL t5_src_cnt_sat got %h exp %h", src_cnt_o, feat(8'h13)); else n_pass++;
        step(1'b1, 4'b0010, 4'hF, 1'b1);
        n_checks++; if (error_pulse_o !== 1'b1) $display("FAIL t5_clr_pulse got %b exp 1", error_pulse_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (bad_cnt_o !== 2'd1) $display("FAIL t5_clr_with_pulse got %0d exp 1", bad_cnt_o); else n_pass++;
        n_checks++; if (src_cnt_o !== 8'h00) $display("FAIL t5_src_cnt_clr got %h exp 0", src_cnt_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (cause_valid_o !== 1'b1 || cause_o !== 4'b0010) $display("FAIL t5_cause got %b/%b exp 1/0010", cause_valid_o, cause_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (src_cnt_o !== feat(8'h04)) $display("FAIL t5_src_cnt_after got %h exp %h", src_cnt_o, feat(8'h04)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'b0001, 4'hF, 1'b0);
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        step(1'b0, 4'b0100, 4'hF, 1'b0);
        n_checks++; if (cause_valid_o !== 1'b1) $display("FAIL b2b_cause_valid got %b exp 1", cause_valid_o); else n_pass++;
        n_checks++; if (cause_o !== 4'b0001) $display("FAIL b2b_old_cause got %b exp 0001", cause_o); else n_pass++;
        n_checks++; if (error_pulse_o !== 1'b1) $display("FAIL b2b_pulse got %b exp 1", error_pulse_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (cause_o !== 4'b0100) $display("FAIL b2b_new_cause got %b exp 0100", cause_o); else n_pass++;
        n_checks++; if (frame_bad_o !== 1'b1) $display("FAIL b2b_frame_bad got %b exp 1", frame_bad_o); else n_pass++;
        step(1'b0, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (bad_cnt_o !== 2'd3) $display("FAIL b2b_bad_cnt got %0d exp 3", bad_cnt_o); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b1000, 4'hF, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0);
        step(1'b1, 4'b0000, 4'hF, 1'b0);
        n_checks++; if (frame_bad_o !== 1'b1) $display("FAIL rmf_pre_bad got %b exp 1", frame_bad_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({error_pulse_o, frame_bad_o, cause_o, cause_valid_o} !== 7'd0) $display("FAIL rmf_async_state got %b exp 0", {error_pulse_o, frame_bad_o, cause_o, cause_valid_o}); else n_pass++;
        n_checks++; if ({bad_cnt_o, src_cnt_o} !== 10'd0) $display("FAIL rmf_async_cnt got %h exp 0", {bad_cnt_o, src_cnt_o}); else n_pass++;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'b0000, 4'hF, 1'b0);
            n_checks++; if (error_pulse_o !== 1'b0) $display("FAIL rmf_pulse c=%0d got %b exp 0", c, error_pulse_o); else n_pass++;
            n_checks++; if (frame_bad_o !== 1'b0) $display("FAIL rmf_frame_bad c=%0d got %b exp 0", c, frame_bad_o); else n_pass++;
        end
        step(1'b0, 4'b0000, 4'hF, 1'b0);
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] mask, err;
        logic v, c;
        mask = 4'hF;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 49) == 0) mask = 4'($urandom());
            v   = ($urandom_range(0, 9) < 7);
            err = ($urandom_range(0, 14) == 0) ? 4'($urandom()) : 4'h0;
            c   = ($urandom_range(0, 59) == 0);
            step(v, err, mask, c);
            n_checks++; if (error_pulse_o !== (!m_bad && ((err & mask) != 0))) $display("FAIL rnd_pulse k=%0d got %b", k, error_pulse_o); else n_pass++;
            n_checks++; if (frame_bad_o !== m_bad) $display("FAIL rnd_frame_bad k=%0d got %b exp %b", k, frame_bad_o, m_bad); else n_pass++;
            n_checks++; if (cause_o !== m_cause) $display("FAIL rnd_cause k=%0d got %b exp %b", k, cause_o, m_cause); else n_pass++;
            n_checks++; if (cause_valid_o !== m_cv) $display("FAIL rnd_cause_valid k=%0d got %b exp %b", k, cause_valid_o, m_cv); else n_pass++;
            n_checks++; if (bad_cnt_o !== m_cnt[CNT_W-1:0]) $display("FAIL rnd_bad_cnt k=%0d got %0d exp %0d", k, bad_cnt_o, m_cnt); else n_pass++;
            n_checks++; if (src_cnt_o !== exp_src_cnt()) $display("FAIL rnd_src_cnt k=%0d got %h exp %h", k, src_cnt_o, exp_src_cnt()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_multi_cause();
        test_masked();
        test_late_crc();
        test_saturation();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
